inst_cache: RTL and testbench
=============================

INST_CACHE -- requirements
Module: inst_cache

Interface
REQ-001 Parameter LINES, default 16, number of direct-mapped lines (power of two, at least 2).
REQ-002 Parameter WORDS, default 4, 32-bit words per line (power of two, at least 2).
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst_b  input  1  reset, asynchronous, active-low.
REQ-005 inst_addr  input  32  fetch address from the core (PC); bits [1:0] ignored.
REQ-006 inst  output  32  fetched instruction word.
REQ-007 inst_valid  output  1  inst is valid for inst_addr this cycle; the core holds its PC while this is low.
REQ-008 flush  input  1  invalidate all lines.
REQ-009 mem_addr  output  32  word address of the refill beat (bits [1:0] = 0).
REQ-010 mem_req  output  1  refill beat request.
REQ-011 mem_rdata  input  32  refill word, big-endian byte order as used by the core.
REQ-012 mem_ready  input  1  beat accepted; mem_rdata is valid in the same cycle.
REQ-013 hit_count, miss_count  output  32 each  statistics; present only under ICACHE_STATS_EN.

Function
REQ-014 Address split: offset = inst_addr[log2(WORDS)+1:2]; index = next log2(LINES) bits; tag = remaining upper bits.
REQ-015 In IDLE, a hit (valid[index] and tag match) drives inst and inst_valid=1 combinationally in the same cycle.
REQ-016 In IDLE, a miss drives inst_valid=0, latches line base = {tag, index, 0}, and enters REFILL on the next edge.
REQ-017 In REFILL, mem_req=1 and mem_addr = base + 4*beat, with beat counting 0..WORDS-1 in ascending order, no wrap.
REQ-018 mem_req stays high and mem_addr stays stable until mem_ready=1; each handshake writes mem_rdata into the data array and increments beat.
REQ-019 On the handshake with beat=WORDS-1, the cache sets valid and writes the tag, and the FSM returns to IDLE; the hit is visible on the following cycle.
REQ-020 Minimum miss penalty is WORDS+1 cycles (mem_ready tied high); there is no upper bound.
REQ-021 inst_valid=0 throughout REFILL, even if inst_addr changes to a resident line.
REQ-022 If inst_addr changes during REFILL, the refill of the latched line completes unchanged.
REQ-023 A flush in IDLE clears all valid bits at the next edge; inst_valid=0 during the flush cycle.
REQ-024 A flush in REFILL finishes the current beat handshake, discards the line (valid stays 0), clears all valid bits, and returns to IDLE.
REQ-025 The target line's valid bit is cleared at refill start, so a partial line is never reported as a hit.
REQ-026 FSM states are IDLE and REFILL only; any illegal encoding returns to IDLE.

Reset
REQ-027 rst_b=0 asynchronously sets: state to IDLE, all valid bits 0, beat 0, mem_req 0, mem_addr 0.
REQ-028 inst_valid is 0 whenever rst_b=0 or the cache is empty after reset; inst is not defined while inst_valid=0.
REQ-029 Reset mid-refill abandons the refill; no line becomes valid.
REQ-030 Data and tag arrays are not reset.

Configuration
REQ-031 When macro ICACHE_STATS_EN is defined, hit_count increments once per cycle with IDLE and a hit, and miss_count increments once per refill start; both wrap modulo 2^32 and reset to 0.
REQ-032 Without ICACHE_STATS_EN, the counter ports and logic are absent and all other behaviour is identical.

Structure
REQ-033 Shared package mips_pkg holds the cache FSM state enum, the default LINES and WORDS constants, and the XLEN=32 constant.
REQ-034 A single sub-module, icache_refill_fsm, owns the state, beat counter, mem_req and mem_addr; the arrays and hit logic stay in inst_cache.

Verification
REQ-035 After reset, inst_addr=0x0 and memory returns 0x11111111/22222222/33333333/44444444 with 2-cycle latency per beat. Required: mem_addr sequence 0x0, 0x4, 0x8, 0xC; then inst=0x11111111 with inst_valid=1.
REQ-036 After the REQ-035 fill, inst_addr=0xC. Required: same-cycle hit with inst=0x44444444 and no mem_req.
REQ-037 Conflict: 0x0 is resident, then inst_addr=0x100 with LINES=16 and WORDS=4. Required: refill from 0x100; a subsequent read of 0x0 misses again.
REQ-038 Flush asserted during beat 2 of a refill. Required: beat 2 completes, the FSM returns to IDLE, and the same address then misses and refetches from beat 0.
REQ-039 rst_b pulled low during beat 1 of a refill. Required: mem_req=0 immediately, and the address misses after reset.
REQ-040 With ICACHE_STATS_EN, run REQ-035 through REQ-037. Required: miss_count=3 and hit_count equals the number of valid-hit cycles.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the instruction-fetch path: the data width,
// the default instruction-cache geometry and the refill FSM state encoding.
package mips_pkg;

  localparam int XLEN         = 32;
  localparam int ICACHE_LINES = 16;
  localparam int ICACHE_WORDS = 4;

  // One-hot states; the two unused encodings are caught and sent to IDLE.
  typedef enum logic [1:0] {
    IC_IDLE   = 2'b01,
    IC_REFILL = 2'b10
  } icache_state_t;

endpackage

// File: rtl/icache_refill_fsm.sv
// Refill sequencer for inst_cache. It owns the FSM state, the beat counter
// and the registered memory request/address. Beats go out in ascending order
// from the latched line base. A flush during a refill lets the in-flight
// beat finish, then returns to IDLE without reporting a completed line.
module icache_refill_fsm
  import mips_pkg::*;
#(
  parameter int WORDS = ICACHE_WORDS
) (
  input  logic            clk,
  input  logic            rst_b,
  input  logic            start,
  input  logic            flush,
  input  logic            mem_ready,
  input  logic [XLEN-1:0] line_base,
  output icache_state_t   state,
  output logic            mem_req,
  output logic [XLEN-1:0] mem_addr,
  output logic            beat_wr,
  output logic            fill_done
);

  localparam int OFF_W = $clog2(WORDS);

  logic [OFF_W-1:0] beat;
  logic             abort;
  logic             last_beat;

  assign last_beat = (beat == OFF_W'(WORDS - 1));
  assign beat_wr   = (state == IC_REFILL) && mem_ready;
  // A line that saw a flush at any point in its refill is never reported.
  assign fill_done = beat_wr && last_beat && !flush && !abort;

  // FSM: start a refill on a miss, step one beat per handshake, stop on the
  // last beat or on the first handshake after a flush.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state    <= IC_IDLE;
      beat     <= '0;
      abort    <= 1'b0;
      mem_req  <= 1'b0;
      mem_addr <= '0;
    end else begin
      case (state)
        IC_IDLE: begin
          if (start) begin
            state    <= IC_REFILL;
            beat     <= '0;
            abort    <= 1'b0;
            mem_req  <= 1'b1;
            mem_addr <= line_base;
          end
        end
        IC_REFILL: begin
          if (flush) abort <= 1'b1;
          if (mem_ready) begin
            if (last_beat || flush || abort) begin
              state   <= IC_IDLE;
              beat    <= '0;
              abort   <= 1'b0;
              mem_req <= 1'b0;
            end else begin
              beat     <= beat + 1'b1;
              mem_addr <= mem_addr + 32'd4;
            end
          end
        end
        default: begin
          state   <= IC_IDLE;
          beat    <= '0;
          abort   <= 1'b0;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/inst_cache.sv
// Direct-mapped instruction cache. Hits are answered combinationally in IDLE.
// Misses hand the line base to icache_refill_fsm, which fetches the line one
// word per handshake. Optional hit/miss statistics are built only when the
// macro ICACHE_STATS_EN is defined.
module inst_cache
  import mips_pkg::*;
#(
  parameter int LINES = ICACHE_LINES,
  parameter int WORDS = ICACHE_WORDS
) (
  input  logic            clk,
  input  logic            rst_b,
  input  logic [XLEN-1:0] inst_addr,
  output logic [XLEN-1:0] inst,
  output logic            inst_valid,
  input  logic            flush,
  output logic [XLEN-1:0] mem_addr,
  output logic            mem_req,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_ready
`ifdef ICACHE_STATS_EN
  ,
  output logic [XLEN-1:0] hit_count,
  output logic [XLEN-1:0] miss_count
`endif
);

  localparam int OFF_W   = $clog2(WORDS);
  localparam int IDX_W   = $clog2(LINES);
  localparam int TAG_LSB = OFF_W + IDX_W + 2;
  localparam int TAG_W   = XLEN - TAG_LSB;

  logic [TAG_W-1:0] tag_arr  [LINES];
  logic [XLEN-1:0]  data_arr [LINES*WORDS];
  logic [LINES-1:0] valid;

  icache_state_t    state;
  logic             is_idle;
  logic             hit;
  logic             start;
  logic             beat_wr;
  logic             fill_done;
  logic [XLEN-1:0]  line_base;

  logic [OFF_W-1:0] rd_off;
  logic [IDX_W-1:0] rd_idx;
  logic [TAG_W-1:0] rd_tag;
  logic [OFF_W-1:0] wr_off;
  logic [IDX_W-1:0] wr_idx;
  logic [TAG_W-1:0] wr_tag;
  logic [1:0]       unused_byte_sel;

  // Fetch address split; the byte-select bits carry no information.
  assign rd_off          = inst_addr[OFF_W+1:2];
  assign rd_idx          = inst_addr[TAG_LSB-1:OFF_W+2];
  assign rd_tag          = inst_addr[XLEN-1:TAG_LSB];
  assign unused_byte_sel = inst_addr[1:0];

  // The refill address already carries {tag, index, beat}, so the write side
  // keeps following the latched line even if the core's PC moves.
  assign wr_off = mem_addr[OFF_W+1:2];
  assign wr_idx = mem_addr[TAG_LSB-1:OFF_W+2];
  assign wr_tag = mem_addr[XLEN-1:TAG_LSB];

  assign is_idle    = (state == IC_IDLE);
  assign hit        = valid[rd_idx] && (tag_arr[rd_idx] == rd_tag);
  assign inst       = data_arr[{rd_idx, rd_off}];
  assign inst_valid = is_idle && hit && !flush;
  assign start      = is_idle && !hit && !flush;
  assign line_base  = {inst_addr[XLEN-1:OFF_W+2], {(OFF_W + 2){1'b0}}};

  icache_refill_fsm #(
    .WORDS (WORDS)
  ) u_refill (
    .clk       (clk),
    .rst_b     (rst_b),
    .start     (start),
    .flush     (flush),
    .mem_ready (mem_ready),
    .line_base (line_base),
    .state     (state),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .beat_wr   (beat_wr),
    .fill_done (fill_done)
  );

  // Valid bits: flush clears everything; a refill start drops the target
  // line so a half-written line never hits; a clean last beat sets it.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      valid <= '0;
    end else if (flush) begin
      valid <= '0;
    end else begin
      if (start)     valid[rd_idx] <= 1'b0;
      if (fill_done) valid[wr_idx] <= 1'b1;
    end
  end

  // Data and tag storage, written beat by beat during a refill.
  // NOTE: the arrays have no reset; the valid bits alone decide what can hit,
  // which keeps the storage mappable onto plain RAM.
  always_ff @(posedge clk) begin
    if (beat_wr)   data_arr[{wr_idx, wr_off}] <= mem_rdata;
    if (fill_done) tag_arr[wr_idx]            <= wr_tag;
  end

`ifdef ICACHE_STATS_EN
  // Statistics: one hit per IDLE cycle with a hit, one miss per refill start.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (is_idle && hit) hit_count  <= hit_count + 1'b1;
      if (start)          miss_count <= miss_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_inst_cache.sv
// Scoreboard bench for inst_cache (LINES=16, WORDS=4). Stimulus pushes the
// expected refill beat addresses and fetched words; a monitor pops and
// compares them whenever the DUT shows a handshake or a valid instruction.
module tb_inst_cache;

  logic        clk = 1'b0;
  logic        rst_b = 1'b0;
  logic [31:0] inst_addr = 32'h0;
  logic [31:0] inst;
  logic        inst_valid;
  logic        flush = 1'b0;
  logic [31:0] mem_addr;
  logic        mem_req;
  logic [31:0] mem_rdata = 32'h0;
  logic        mem_ready = 1'b0;
`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] addr_q[$];
  logic [31:0] inst_q[$];
  int          inst_issued = 0;
  int          inst_seen = 0;
  int          hit_seen = 0;
  int          mem_lat = 2;

  inst_cache #(.LINES(16), .WORDS(4)) dut (
    .clk        (clk),
    .rst_b      (rst_b),
    .inst_addr  (inst_addr),
    .inst       (inst),
    .inst_valid (inst_valid),
    .flush      (flush),
    .mem_addr   (mem_addr),
    .mem_req    (mem_req),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready)
`ifdef ICACHE_STATS_EN
    ,
    .hit_count  (hit_count),
    .miss_count (miss_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Backing memory contents: a fixed pattern for the first line, and an
  // address-derived word everywhere else.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a < 32'h10) begin
      case (a[3:2])
        2'd0:    return 32'h11111111;
        2'd1:    return 32'h22222222;
        2'd2:    return 32'h33333333;
        default: return 32'h44444444;
      endcase
    end
    return {a[15:0], ~a[15:0]};
  endfunction

  // Memory responder: accepts a beat every mem_lat cycles of request.
  initial begin
    int cnt;
    cnt = 0;
    forever begin
      @(posedge clk);
      #1;
      if (mem_req) begin
        if (cnt >= mem_lat - 1) begin
          mem_ready = 1'b1;
          mem_rdata = mem_word(mem_addr);
          cnt = 0;
        end else begin
          mem_ready = 1'b0;
          cnt++;
        end
      end else begin
        mem_ready = 1'b0;
        cnt = 0;
      end
    end
  end

  // Monitor: compare every refill handshake and every awaited instruction.
  initial begin
    logic [31:0] exp;
    forever begin
      @(negedge clk);
      if (rst_b && mem_req && mem_ready) begin
        if (addr_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_beat: got mem_addr 0x%08h, expected no request", mem_addr);
        end else begin
          exp = addr_q.pop_front();
          check("mem_addr", mem_addr, exp);
        end
      end
      if (rst_b && inst_valid) begin
        hit_seen++;
        if (inst_seen != inst_issued) begin
          if (inst_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_inst: got 0x%08h, expected empty scoreboard", inst);
          end else begin
            exp = inst_q.pop_front();
            check("inst", inst, exp);
          end
          inst_seen++;
        end
      end
    end
  end

  // Issue one fetch; called at posedge+1. Returns the number of edges until
  // the instruction was delivered (1 = same-cycle hit). With detour set, the
  // PC moves to resident address 0x0 for two cycles mid-refill.
  task automatic fetch(input logic [31:0] a, input logic [31:0] exp_inst,
                       input int n_beats, input bit detour, output int cycles);
    logic [31:0] base;
    base = a & 32'hFFFF_FFF0;
    for (int i = 0; i < n_beats; i++) addr_q.push_back(base + 32'(4 * i));
    inst_q.push_back(exp_inst);
    inst_issued++;
    inst_addr = a;
    cycles = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #1;
      cycles++;
      if (inst_seen == inst_issued) break;
      if (detour && cycles == 2) inst_addr = 32'h0;
      if (detour && cycles == 4) inst_addr = a;
    end
    check("fetch_done", inst_seen, inst_issued);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   cyc;
    logic found;

    // Reset state
    #23;
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_inst_valid", inst_valid, 1'b0);
    @(posedge clk);
    #1;
    rst_b = 1'b1;

    // Cold miss at 0x0, 2-cycle beats: 1 + 2*WORDS cycles until the hit
    mem_lat = 2;
    fetch(32'h0, 32'h11111111, 4, 1'b0, cyc);
    check("miss_lat2_cycles", cyc - 1, 9);

    // Resident hits answer in the same cycle with no request
    fetch(32'hC, 32'h44444444, 0, 1'b0, cyc);
    check("hit_same_cycle", cyc, 1);
    check("hit_no_req", mem_req, 1'b0);
    fetch(32'h4, 32'h22222222, 0, 1'b0, cyc);
    check("hit2_same_cycle", cyc, 1);

    // Minimum miss penalty with mem_ready effectively tied high
    mem_lat = 1;
    fetch(32'h10, 32'h0010FFEF, 4, 1'b0, cyc);
    check("min_miss_penalty", cyc - 1, 5);

    // PC wanders to a resident line mid-refill: no hit, refill unchanged
    mem_lat = 2;
    fetch(32'h20, 32'h0020FFDF, 4, 1'b1, cyc);

    // Conflict on index 0: 0x100 evicts 0x0, which then misses again
    fetch(32'h100, 32'h0100FEFF, 4, 1'b0, cyc);
    fetch(32'h0, 32'h11111111, 4, 1'b0, cyc);
    check("conflict_remiss", cyc > 1, 1'b1);

`ifdef ICACHE_STATS_EN
    check("miss_count", miss_count, 32'd5);
    check("hit_count", hit_count, 32'(hit_seen));
`endif

    // Flush in IDLE on a resident address: no valid that cycle, then miss
    flush = 1'b1;
    @(negedge clk);
    check("flush_cycle_valid", inst_valid, 1'b0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    fetch(32'h0, 32'h11111111, 4, 1'b0, cyc);
    check("flush_remiss", cyc > 1, 1'b1);

    // Flush during beat 2: beat 2 completes, line dropped, refetch from beat 0
    addr_q.push_back(32'h40);
    addr_q.push_back(32'h44);
    addr_q.push_back(32'h48);
    for (int i = 0; i < 4; i++) addr_q.push_back(32'h40 + 32'(4 * i));
    inst_q.push_back(32'h0040FFBF);
    inst_issued++;
    inst_addr = 32'h40;
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      if (mem_req && mem_addr == 32'h48) begin
        found = 1'b1;
        break;
      end
    end
    check("beat2_reached", found, 1'b1);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      if (inst_seen == inst_issued) break;
    end
    check("flush_refill_done", inst_seen, inst_issued);

    // Reset during beat 1: request drops at once, line is not kept
    addr_q.push_back(32'h80);
    inst_addr = 32'h80;
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      if (mem_req && mem_addr == 32'h84) begin
        found = 1'b1;
        break;
      end
    end
    check("beat1_reached", found, 1'b1);
    #2;
    rst_b = 1'b0;
    #1;
    check("rst_mid_mem_req", mem_req, 1'b0);
    check("rst_mid_mem_addr", mem_addr, 32'h0);
    check("rst_mid_inst_valid", inst_valid, 1'b0);
    @(posedge clk);
    #1;
    rst_b = 1'b1;
    fetch(32'h80, 32'h0080FF7F, 4, 1'b0, cyc);
    check("rst_remiss", cyc > 1, 1'b1);

    check("addr_q_drained", addr_q.size(), 0);
    check("inst_q_drained", inst_q.size(), 0);
    $display("hit cycles observed: %0d", hit_seen);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
